// File: rtl/kv_server_responder.sv
`default_nettype none
// ============================================================================
// Module   : kv_server_responder
// Brief    : Server endpoint of the frequency-absorb key-value protocol.
//            Parses the header beat of each request and drains the remaining
//            beats. It keeps a direct-mapped key/value table and returns a
//            single-beat READ_REPLY / WRITE_REPLY packet toward the client.
// Revision : 1.0  initial release
// ============================================================================
module kv_server_responder #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_WIDTH            = 32,
    parameter int VALUE_WIDTH          = 128,
    parameter int ADDR_WIDTH           = 4
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    output logic [31:0]                          stat_rd_hit,
    output logic [31:0]                          stat_rd_miss,
    output logic [31:0]                          stat_drop
);

    // ------------------------------------------------------------------------
    // Header layout and protocol constants
    // ------------------------------------------------------------------------
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int TAG_WIDTH  = KEY_WIDTH - ADDR_WIDTH;
    localparam int KEY_LSB    = 8;
    localparam int VAL_LSB    = KEY_LSB + KEY_WIDTH;
    localparam int STAT_LSB   = VAL_LSB + VALUE_WIDTH;
    localparam int OPQ_LSB    = STAT_LSB + 8;
    localparam int OPQ_WIDTH  = C_S_AXIS_DATA_WIDTH - OPQ_LSB;
    localparam int KEEP_WIDTH = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UHI_WIDTH  = C_S_AXIS_TUSER_WIDTH - 32;

    localparam logic [7:0]  OP_READ_REQUEST = 8'd0;
    localparam logic [7:0]  OP_READ_REPLY   = 8'd1;
    localparam logic [7:0]  OP_WRITE        = 8'd2;
    localparam logic [7:0]  OP_DELETE       = 8'd3;
    localparam logic [7:0]  OP_STASH_SYN    = 8'd5;
    localparam logic [7:0]  OP_WRITE_REPLY  = 8'd6;
    localparam logic [15:0] REPLY_LENGTH    = 16'd32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_RESP   = 3'd3,
        ST_REPLY  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Captured request header
    logic [7:0]             req_opcode;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic [OPQ_WIDTH-1:0]   req_opaque;
    logic [UHI_WIDTH-1:0]   req_user_hi;
    logic [7:0]             req_dst;
    logic [7:0]             req_src;

    // Table storage
    logic [DEPTH-1:0]       valid_bits;
    logic [TAG_WIDTH-1:0]   tag_mem   [DEPTH];
    logic [VALUE_WIDTH-1:0] value_mem [DEPTH];

    // Registered table read result
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [VALUE_WIDTH-1:0] rd_value;

    // Decode of the captured request
    logic [ADDR_WIDTH-1:0]  req_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   lookup_hit;
    logic                   op_is_read;
    logic                   op_is_write;
    logic                   op_is_delete;
    logic                   op_is_stash;
    logic                   op_is_store;
    logic                   op_has_reply;
    logic                   op_is_drop;

    // Reply assembly
    logic [7:0]                      reply_opcode;
    logic [7:0]                      reply_status;
    logic [VALUE_WIDTH-1:0]          reply_value;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  reply_data;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] reply_user;

    // The keep mask, the request status byte and the request length field
    // carry no meaning for the server.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tdata[STAT_LSB +: 8], s_axis_tuser[15:0]};

    assign req_index    = req_key[ADDR_WIDTH-1:0];
    assign req_tag      = req_key[KEY_WIDTH-1:ADDR_WIDTH];
    assign lookup_hit   = rd_valid && (rd_tag == req_tag);

    assign op_is_read   = (req_opcode == OP_READ_REQUEST);
    assign op_is_write  = (req_opcode == OP_WRITE);
    assign op_is_delete = (req_opcode == OP_DELETE);
    assign op_is_stash  = (req_opcode == OP_STASH_SYN);
    assign op_is_store  = op_is_write || op_is_stash;
    assign op_has_reply = op_is_read || op_is_write || op_is_delete;
    assign op_is_drop   = !(op_has_reply || op_is_stash);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and input back-pressure; one packet in flight.
    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    state_next = s_axis_tlast ? ST_LOOKUP : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = op_has_reply ? ST_REPLY : ST_IDLE;
            end
            ST_REPLY: begin
                if (m_axis_tready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Latch header fields from the first beat; later beats are ignored.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            req_opcode  <= '0;
            req_key     <= '0;
            req_value   <= '0;
            req_opaque  <= '0;
            req_user_hi <= '0;
            req_dst     <= '0;
            req_src     <= '0;
        end else if (state == ST_IDLE && s_axis_tvalid) begin
            req_opcode  <= s_axis_tdata[7:0];
            req_key     <= s_axis_tdata[KEY_LSB +: KEY_WIDTH];
            req_value   <= s_axis_tdata[VAL_LSB +: VALUE_WIDTH];
            req_opaque  <= s_axis_tdata[OPQ_LSB +: OPQ_WIDTH];
            req_user_hi <= s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:32];
            req_dst     <= s_axis_tuser[31:24];
            req_src     <= s_axis_tuser[23:16];
        end
    end

    // Registered table read, performed once the whole packet has arrived.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rd_valid <= 1'b0;
            rd_tag   <= '0;
            rd_value <= '0;
        end else if (state == ST_LOOKUP) begin
            rd_valid <= valid_bits[req_index];
            rd_tag   <= tag_mem[req_index];
            rd_value <= value_mem[req_index];
        end
    end

    // Valid bits: set by WRITE/STASH_SYN, cleared by a DELETE that hits.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            valid_bits <= '0;
        end else if (state == ST_RESP) begin
            if (op_is_store) begin
                valid_bits[req_index] <= 1'b1;
            end else if (op_is_delete && lookup_hit) begin
                valid_bits[req_index] <= 1'b0;
            end
        end
    end

    // Tag/value payload; an entry is meaningless until its valid bit is set,
    // so this storage carries no reset.
    always_ff @(posedge axis_aclk) begin
        if (state == ST_RESP && op_is_store) begin
            tag_mem[req_index]   <= req_tag;
            value_mem[req_index] <= req_value;
        end
    end

    // Reply opcode/status/value from the opcode and lookup result.
    always_comb begin
        reply_opcode = OP_WRITE_REPLY;
        reply_status = 8'h00;
        reply_value  = '0;
        if (op_is_read) begin
            reply_opcode = OP_READ_REPLY;
            if (lookup_hit) begin
                reply_status = 8'h01;
                reply_value  = rd_value;
            end
        end else if (op_is_write) begin
            reply_status = 8'h01;
        end else if (op_is_delete && lookup_hit) begin
            reply_status = 8'h01;
        end
    end

    // The reply heads back to the requester, so source and destination swap.
    assign reply_data = {req_opaque, reply_status, reply_value, req_key, reply_opcode};
    assign reply_user = {req_user_hi, req_src, req_dst, REPLY_LENGTH};

    // Reply beat register; held stable until the downstream accepts it.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (state == ST_RESP && op_has_reply) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= reply_data;
            m_axis_tkeep  <= {KEEP_WIDTH{1'b1}};
            m_axis_tuser  <= reply_user;
            m_axis_tlast  <= 1'b1;
        end else if (state == ST_REPLY && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Event counters; they wrap naturally at 32 bits.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            stat_rd_hit  <= '0;
            stat_rd_miss <= '0;
            stat_drop    <= '0;
        end else if (state == ST_RESP) begin
            if (op_is_read && lookup_hit) begin
                stat_rd_hit <= stat_rd_hit + 32'd1;
            end
            if (op_is_read && !lookup_hit) begin
                stat_rd_miss <= stat_rd_miss + 32'd1;
            end
            if (op_is_drop) begin
                stat_drop <= stat_drop + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kv_server_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_kv_server_responder
// Brief    : Self-checking bench for kv_server_responder. Directed scenarios
//            plus randomized traffic compared against a key/value table model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kv_server_responder;

    logic         axis_aclk = 1'b0;
    logic         axis_resetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [31:0]  stat_rd_hit;
    logic [31:0]  stat_rd_miss;
    logic [31:0]  stat_drop;

    kv_server_responder dut (
        .axis_aclk     (axis_aclk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .stat_rd_hit   (stat_rd_hit),
        .stat_rd_miss  (stat_rd_miss),
        .stat_drop     (stat_drop)
    );

    always #5 axis_aclk = ~axis_aclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each slot remembers the full key that owns it.
    bit           m_valid [16];
    logic [31:0]  m_key   [16];
    logic [127:0] m_val   [16];
    logic [31:0]  exp_hit, exp_miss, exp_drop;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        exp_drop = 0;
    endtask

    task automatic check_counters();
        check_val("stat_rd_hit",  stat_rd_hit,  exp_hit);
        check_val("stat_rd_miss", stat_rd_miss, exp_miss);
        check_val("stat_drop",    stat_drop,    exp_drop);
    endtask

    // Sends one packet, predicts its effect and checks reply, timing and counters.
    task automatic run_pkt(input logic [7:0] op, input logic [31:0] key, input logic [127:0] val,
                           input int nbeats, input logic [127:0] user, input logic [79:0] opaque,
                           input int stall, input bit gaps);
        logic [255:0] hdr, snap_data;
        logic [127:0] snap_user, exp_user;
        logic [7:0]   rop, rstat;
        logic [127:0] rval;
        bit           reply, hit;
        int           idx, lat, guard;

        hdr = {opaque, 8'($urandom), val, key, op};
        idx = int'(key[3:0]);
        hit = m_valid[idx] && (m_key[idx] == key);
        reply = 1'b0; rop = 8'd0; rstat = 8'd0; rval = '0;
        case (op)
            8'd0: begin
                reply = 1'b1; rop = 8'd1;
                if (hit) begin rstat = 8'h01; rval = m_val[idx]; exp_hit++; end
                else exp_miss++;
            end
            8'd2: begin
                reply = 1'b1; rop = 8'd6; rstat = 8'h01;
                m_valid[idx] = 1'b1; m_key[idx] = key; m_val[idx] = val;
            end
            8'd3: begin
                reply = 1'b1; rop = 8'd6; rstat = hit ? 8'h01 : 8'h00;
                if (hit) m_valid[idx] = 1'b0;
            end
            8'd5: begin
                m_valid[idx] = 1'b1; m_key[idx] = key; m_val[idx] = val;
            end
            default: exp_drop++;
        endcase
        exp_user = {user[127:32], user[23:16], user[31:24], 16'd32};

        m_axis_tready = (stall == 0);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 1) == 1) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge axis_aclk);
            end
            s_axis_tdata  = (b == 0) ? hdr : rand256();
            s_axis_tuser  = (b == 0) ? user : rand256()[127:0];
            s_axis_tkeep  = 32'hFFFF_FFFF;
            s_axis_tlast  = (b == nbeats - 1);
            s_axis_tvalid = 1'b1;
            guard = 0;
            while (!s_axis_tready && guard < 50) begin
                @(negedge axis_aclk);
                guard++;
            end
            if (guard >= 50) begin
                check_val("s_tready_timeout", 1'b0, 1'b1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge axis_aclk);
            @(negedge axis_aclk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        // First cycle after the tlast handshake
        check_val("s_tready_busy", s_axis_tready, 1'b0);
        if (reply) begin
            lat = 1;
            while (!m_axis_tvalid && lat < 12) begin
                check_val("s_tready_wait", s_axis_tready, 1'b0);
                @(negedge axis_aclk);
                lat++;
            end
            check_val("reply_latency", lat, 3);
            if (!m_axis_tvalid) return;
            check_val("rep_opcode", m_axis_tdata[7:0], rop);
            check_val("rep_key",    m_axis_tdata[39:8], key);
            check_val("rep_status", m_axis_tdata[175:168], rstat);
            check_val("rep_opaque", m_axis_tdata[255:176], opaque);
            if (op == 8'd0) check_val("rep_value", m_axis_tdata[167:40], rval);
            check_val("rep_tuser",  m_axis_tuser, exp_user);
            check_val("rep_tkeep",  m_axis_tkeep, 32'hFFFF_FFFF);
            check_val("rep_tlast",  m_axis_tlast, 1'b1);
            snap_data = m_axis_tdata;
            snap_user = m_axis_tuser;
            for (int s = 0; s < stall; s++) begin
                @(negedge axis_aclk);
                check_val("stall_valid",  m_axis_tvalid, 1'b1);
                check_val("stall_data",   m_axis_tdata, snap_data);
                check_val("stall_user",   m_axis_tuser, snap_user);
                check_val("stall_tready", s_axis_tready, 1'b0);
            end
            m_axis_tready = 1'b1;
            @(posedge axis_aclk);
            @(negedge axis_aclk);
            check_val("reply_single", m_axis_tvalid, 1'b0);
            check_val("s_tready_back", s_axis_tready, 1'b1);
        end else begin
            check_val("noreply_valid1", m_axis_tvalid, 1'b0);
            @(negedge axis_aclk);
            check_val("noreply_valid2", m_axis_tvalid, 1'b0);
            check_val("s_tready_resp", s_axis_tready, 1'b0);
            @(negedge axis_aclk);
            check_val("noreply_valid3", m_axis_tvalid, 1'b0);
            check_val("s_tready_idle", s_axis_tready, 1'b1);
        end
        check_counters();
    endtask

    localparam logic [127:0] VAL_AA = {16{8'hAA}};
    localparam logic [79:0]  OPQ_D  = 80'h1234_5678_9ABC_DEF0_1122;

    initial begin
        logic [127:0] usr;
        logic [7:0]   ops [12];
        logic [31:0]  k;

        ops = '{8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd3, 8'd5, 8'd4, 8'd1, 8'd6, 8'd9, 8'd255};
        axis_resetn   = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        model_clear();

        repeat (3) @(negedge axis_aclk);
        check_val("rst_tvalid", m_axis_tvalid, 1'b0);
        check_val("rst_tdata",  m_axis_tdata, 256'd0);
        check_val("rst_tuser",  m_axis_tuser, 128'd0);
        check_val("rst_tkeep",  m_axis_tkeep, 32'd0);
        check_val("rst_tlast",  m_axis_tlast, 1'b0);
        axis_resetn = 1'b1;
        @(negedge axis_aclk);
        check_val("rst_s_tready", s_axis_tready, 1'b1);
        check_counters();

        // Directed scenarios
        usr = {96'h0, 8'h01, 8'h04, 16'h0040};
        run_pkt(8'd0, 32'h0000_0005, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd2, 32'h0000_0005, VAL_AA, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd0, 32'h0000_0005, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd2, 32'h0000_0015, 128'h5555, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd0, 32'h0000_0005, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd0, 32'h0000_0015, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd3, 32'h0000_0015, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd3, 32'h0000_0015, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd0, 32'h0000_0015, 128'h0, 1, usr, OPQ_D, 0, 1'b0);
        usr = {rand256()[95:0], 8'h01, 8'h04, 16'h0123};
        run_pkt(8'd2, 32'h0000_0009, 128'hCAFE, 3, usr, OPQ_D, 10, 1'b0);
        check_val("swap_dst_src", m_axis_tuser[31:16], 16'h0401);
        check_val("length_32",    m_axis_tuser[15:0], 16'd32);
        run_pkt(8'd4, 32'h0000_0007, 128'h77, 2, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd5, 32'h0000_0007, 128'h7777, 1, usr, OPQ_D, 0, 1'b0);
        run_pkt(8'd0, 32'h0000_0007, 128'h0, 1, usr, OPQ_D, 0, 1'b0);

        // Randomized traffic over a small key space to force hits and evictions
        for (int n = 0; n < 250; n++) begin
            k = ($urandom_range(0, 7) == 0) ? $urandom
                                            : 32'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            run_pkt(ops[$urandom_range(0, 11)], k, rand256()[127:0], $urandom_range(1, 3),
                    rand256()[127:0], rand256()[79:0], $urandom_range(0, 3), 1'b1);
        end

        // Reset in the middle of a multi-beat packet
        run_pkt(8'd2, 32'h0000_0003, 128'hBEEF, 1, usr, OPQ_D, 0, 1'b0);
        s_axis_tdata  = {OPQ_D, 8'h00, 128'h0, 32'h0000_0003, 8'd0};
        s_axis_tuser  = usr;
        s_axis_tkeep  = 32'hFFFF_FFFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        s_axis_tvalid = 1'b0;
        #2 axis_resetn = 1'b0;
        #1;
        check_val("midrst_tvalid", m_axis_tvalid, 1'b0);
        check_val("midrst_tdata",  m_axis_tdata, 256'd0);
        model_clear();
        repeat (2) @(negedge axis_aclk);
        axis_resetn = 1'b1;
        @(negedge axis_aclk);
        check_val("midrst_s_tready", s_axis_tready, 1'b1);
        check_counters();
        run_pkt(8'd0, 32'h0000_0003, 128'h0, 1, usr, OPQ_D, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/kv_server_responder.md
# kv_server_responder

Server-side endpoint of the frequency-absorb key-value protocol: the responder at the far end of the switch that receives READ_REQUEST, WRITE, DELETE and STASH_SYN packets missed or forwarded by the cache/stash path. It holds a direct-mapped key-value table and emits READ_REPLY / WRITE_REPLY packets back toward the client. It is used as the server model in system benches and as a standalone FPGA key-value server.

## Interface
- C_S_AXIS_DATA_WIDTH, 256: AXIS data width (fixed; header layout below assumes 256).
- C_S_AXIS_TUSER_WIDTH, 128: AXIS tuser width.
- KEY_WIDTH, 32: key width.
- VALUE_WIDTH, 128: value width.
- ADDR_WIDTH, 4: table index width; DEPTH = 2^ADDR_WIDTH entries.
- axis_aclk  in  1  single clock.
- axis_resetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  request stream.
- s_axis_tready  out  1  request accept.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  reply stream.
- m_axis_tready  in  1  reply accept.
- stat_rd_hit, stat_rd_miss, stat_drop  out  32 each  event counters.

## Operation
- Header (first beat): tdata[7:0] opcode, [39:8] key, [167:40] value, [175:168] status, [255:176] opaque. Opcodes: 0 READ_REQUEST, 1 READ_REPLY, 2 WRITE, 3 DELETE, 4 HOT_INSERT, 5 STASH_SYN, 6 WRITE_REPLY.
- Only the first beat is parsed; subsequent beats are consumed and discarded.
- Table entry: valid bit, tag = key[KEY_WIDTH-1:ADDR_WIDTH], value; index = key[ADDR_WIDTH-1:0]. Hit = valid && tag match.
- READ_REQUEST: reply opcode 1; hit -> value field = stored value, status 0x01, stat_rd_hit+1; miss -> value 0, status 0x00, stat_rd_miss+1.
- WRITE and STASH_SYN: write entry (overwrites any tag, sets valid). WRITE replies opcode 6 status 0x01; STASH_SYN sends no reply.
- DELETE: on hit clear valid, reply opcode 6 status 0x01; on miss no table change, status 0x00.
- Any other opcode (1, 4, 6, 7-255): packet drained, no reply, stat_drop+1.
- Reply: single beat, tlast=1, tkeep=32'hFFFFFFFF, key and tdata[255:176] copied from request; tuser copied except tuser[15:0]=32 (length), tuser[31:24] and tuser[23:16] swapped (dst<-src, src<-dst).
- FSM: IDLE (tready=1; capture first beat; tlast -> LOOKUP else DRAIN); DRAIN (tready=1; on tlast -> LOOKUP); LOOKUP (tready=0; registered table read); RESP (tready=0; update table, counters; reply-bearing op -> REPLY, else IDLE); REPLY (tvalid=1, data stable until m_axis_tready, then IDLE).
- Counters 32-bit, wrap 0xFFFFFFFF -> 0.

## Timing
- Reset: all valid bits 0, FSM IDLE, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, counters 0, s_axis_tready=1 once reset released.
- Reset asserted mid-packet or mid-reply: reply dropped, FSM IDLE; remainder of an interrupted input packet is treated as a new packet (upstream must reset together).
- Latency: tlast handshake at cycle N -> m_axis_tvalid=1 at N+3 (LOOKUP N+1, RESP N+2, REPLY N+3).
- s_axis_tready=0 from N+1 until the cycle after reply acceptance (or after RESP for no-reply ops); one packet in flight.
- Table write occurs in RESP, so a back-to-back READ after WRITE to same key hits.
- m_axis_tvalid never drops without m_axis_tready; payload held constant while stalled.
- s_axis_tvalid low in IDLE/DRAIN: state holds.

## Test plan
- After reset, READ_REQUEST key 0x00000005 -> reply opcode 1, status 0x00, value 0, stat_rd_miss=1, tvalid 3 cycles after tlast.
- WRITE key 0x00000005 value 0xAA..AA -> WRITE_REPLY status 0x01; then READ key 5 -> status 0x01, value 0xAA..AA, stat_rd_hit=1.
- WRITE key 0x15 (same index 5, tag differs) then READ key 5 -> miss; READ key 0x15 -> hit.
- DELETE key 0x15 -> status 0x01; second DELETE key 0x15 -> status 0x00; READ -> miss.
- 3-beat WRITE with m_axis_tready held 0 for 10 cycles -> reply stable, s_axis_tready=0 throughout, single reply beat; tuser src/dst 0x01/0x04 -> 0x04/0x01, length 32.
- Opcode 4 packet and STASH_SYN key 7 -> no reply, stat_drop=1; following READ key 7 -> hit.
